// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter
//
// Log-depth barrel shifter for the integer execute path. The shift network
// has one level per amount bit (level k shifts by 2^k when amount bit k is
// set); LEVELS_PER_STAGE consecutive levels share one pipeline register
// stage, giving LAT = ceil(log2(WIDTH) / LEVELS_PER_STAGE) stages. The last
// stage doubles as the output register.
//
// Optional feature: define SHIFTER_ROTATE_EN to make op 2'b11 a rotate
// right. Without it, op 2'b11 passes the operand through unchanged and flags
// the result with out_illegal.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high; empties the pipe, clears outputs
//   in_valid     operation offered
//   in_ready     stage 0 can load this cycle (depends on out_ready/valids only)
//   in_op        2'b00 SLL, 2'b01 SRL, 2'b10 SRA, 2'b11 ROR
//   in_amount    shift amount, 0..WIDTH-1
//   in_data      operand
//   in_tag       carried unchanged to out_tag
//   out_valid    result present
//   out_ready    consumer accepts the result
//   out_data     shifted result
//   out_tag      tag of the result
//   out_zero     out_data == 0
//   out_illegal  op was 2'b11 while rotate is not compiled in
module pipelined_barrel_shifter #(
  parameter int WIDTH            = 32,
  parameter int LEVELS_PER_STAGE = 1,
  parameter int TAG_W            = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [$clog2(WIDTH)-1:0] in_amount,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_zero,
  output logic                     out_illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int LAT     = (SHAMT_W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  // One network level: shift d by sh according to op. sign is the original
  // operand MSB, carried down the pipe so SRA fills correctly at every level.
  function automatic logic [WIDTH-1:0] shift_level(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic             sign,
    input int               sh
  );
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] r;
    // ones in the top sh bit positions
    fill = ~({WIDTH{1'b1}} >> sh);
    case (op)
      2'b00:   r = d << sh;
      2'b01:   r = d >> sh;
      2'b10:   r = (d >> sh) | (sign ? fill : {WIDTH{1'b0}});
`ifdef SHIFTER_ROTATE_EN
      2'b11:   r = (d >> sh) | (d << (WIDTH - sh));
`else
      2'b11:   r = d;
`endif
      default: r = d;
    endcase
    return r;
  endfunction

  // Stage registers
  logic [LAT-1:0]     st_valid;
  logic [LAT-1:0]     st_sign;
  logic [1:0]         st_op   [LAT];
  logic [SHAMT_W-1:0] st_amt  [LAT];
  logic [WIDTH-1:0]   st_data [LAT];
  logic [TAG_W-1:0]   st_tag  [LAT];
  logic               zero_q;
  logic               illegal_q;

  // What each stage would load: stage 0 from the inputs, stage s from s-1
  logic [LAT-1:0]     src_valid;
  logic [LAT-1:0]     src_sign;
  logic [1:0]         src_op   [LAT];
  logic [SHAMT_W-1:0] src_amt  [LAT];
  logic [WIDTH-1:0]   src_data [LAT];
  logic [TAG_W-1:0]   src_tag  [LAT];
  logic [WIDTH-1:0]   nxt_data [LAT];
  logic [LAT-1:0]     load;

  // Load enables, resolved from the output backwards so bubbles collapse
  always_comb begin
    load = {LAT{1'b0}};
    load[LAT-1] = !st_valid[LAT-1] || out_ready;
    for (int s = LAT - 2; s >= 0; s--) begin
      load[s] = !st_valid[s] || load[s+1];
    end
  end

  assign in_ready = load[0];

  // Stage sources and the levels each stage applies on the way in
  always_comb begin
    src_valid[0] = in_valid;
    src_sign[0]  = in_data[WIDTH-1];
    src_op[0]    = in_op;
    src_amt[0]   = in_amount;
    src_data[0]  = in_data;
    src_tag[0]   = in_tag;
    for (int s = 1; s < LAT; s++) begin
      src_valid[s] = st_valid[s-1];
      src_sign[s]  = st_sign[s-1];
      src_op[s]    = st_op[s-1];
      src_amt[s]   = st_amt[s-1];
      src_data[s]  = st_data[s-1];
      src_tag[s]   = st_tag[s-1];
    end
    for (int s = 0; s < LAT; s++) begin
      nxt_data[s] = src_data[s];
      for (int k = 0; k < SHAMT_W; k++) begin
        if (((k / LEVELS_PER_STAGE) == s) && src_amt[s][k]) begin
          nxt_data[s] = shift_level(nxt_data[s], src_op[s], src_sign[s], 1 << k);
        end else begin
          nxt_data[s] = nxt_data[s];
        end
      end
    end
  end

  // Pipeline registers; a stage that does not load holds, which keeps the
  // output stable under backpressure
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_valid  <= {LAT{1'b0}};
      st_sign   <= {LAT{1'b0}};
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
      for (int s = 0; s < LAT; s++) begin
        st_op[s]   <= 2'b00;
        st_amt[s]  <= {SHAMT_W{1'b0}};
        st_data[s] <= {WIDTH{1'b0}};
        st_tag[s]  <= {TAG_W{1'b0}};
      end
    end else begin
      for (int s = 0; s < LAT; s++) begin
        if (load[s]) begin
          st_valid[s] <= src_valid[s];
          st_sign[s]  <= src_sign[s];
          st_op[s]    <= src_op[s];
          st_amt[s]   <= src_amt[s];
          st_data[s]  <= nxt_data[s];
          st_tag[s]   <= src_tag[s];
        end
      end
      if (load[LAT-1]) begin
        zero_q <= (nxt_data[LAT-1] == {WIDTH{1'b0}});
`ifdef SHIFTER_ROTATE_EN
        illegal_q <= 1'b0;
`else
        illegal_q <= (src_op[LAT-1] == 2'b11);
`endif
      end
    end
  end

  assign out_valid   = st_valid[LAT-1];
  assign out_data    = st_data[LAT-1];
  assign out_tag     = st_tag[LAT-1];
  assign out_zero    = zero_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=32, TAG_W=5).
// Main DUT uses LEVELS_PER_STAGE=1 (LAT=5); two extra instances with
// LEVELS_PER_STAGE=2 (LAT=3) and 5 (LAT=1) share the inputs and are used for
// the latency scenario. Results of the main DUT are checked by a scoreboard
// queue filled when an input transfer is seen.
module tb_pipelined_barrel_shifter;

`ifdef SHIFTER_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_op;
  logic [4:0]  in_amount;
  logic [31:0] in_data;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready, out_valid, out_zero, out_illegal;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        a2_in_ready, a2_out_valid, a2_out_zero, a2_out_illegal;
  logic [31:0] a2_out_data;
  logic [4:0]  a2_out_tag;
  logic        a5_in_ready, a5_out_valid, a5_out_zero, a5_out_illegal;
  logic [31:0] a5_out_data;
  logic [4:0]  a5_out_tag;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(32), .LEVELS_PER_STAGE(1), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_amount(in_amount), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_zero(out_zero), .out_illegal(out_illegal));

  pipelined_barrel_shifter #(.WIDTH(32), .LEVELS_PER_STAGE(2), .TAG_W(5)) dut_lps2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a2_in_ready),
    .in_op(in_op), .in_amount(in_amount), .in_data(in_data), .in_tag(in_tag),
    .out_valid(a2_out_valid), .out_ready(out_ready), .out_data(a2_out_data),
    .out_tag(a2_out_tag), .out_zero(a2_out_zero), .out_illegal(a2_out_illegal));

  pipelined_barrel_shifter #(.WIDTH(32), .LEVELS_PER_STAGE(5), .TAG_W(5)) dut_lps5 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a5_in_ready),
    .in_op(in_op), .in_amount(in_amount), .in_data(in_data), .in_tag(in_tag),
    .out_valid(a5_out_valid), .out_ready(out_ready), .out_data(a5_out_data),
    .out_tag(a5_out_tag), .out_zero(a5_out_zero), .out_illegal(a5_out_illegal));

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        zero;
    logic        illegal;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  amt;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  exp_t sb[$];
  int   pop_cyc[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   send_waits = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference shifter, written independently of the level structure
  function automatic logic [31:0] model(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
    logic [31:0] r;
    case (op)
      2'b00:   r = d << a;
      2'b01:   r = d >> a;
      2'b10:   r = $unsigned($signed(d) >>> a);
      default: r = ROT ? ((d >> a) | (d << (6'd32 - {1'b0, a}))) : d;
    endcase
    return r;
  endfunction

  function automatic void expect_result(input logic [31:0] d, input logic [4:0] tag, input logic [1:0] op);
    exp_t x;
    x.data    = d;
    x.tag     = tag;
    x.zero    = (d == 32'd0);
    x.illegal = (op == 2'b11) && !ROT;
    sb.push_back(x);
  endfunction

  // Output monitor: every output transfer must match the queue head
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got tag %0d data 0x%08h expected no result", out_tag, out_data);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_tag", {27'd0, out_tag}, {27'd0, e.tag});
        chk("out_zero", {31'd0, out_zero}, {31'd0, e.zero});
        chk("out_illegal", {31'd0, out_illegal}, {31'd0, e.illegal});
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Offer one op and wait (bounded) for it to be accepted
  task automatic send(input logic [1:0] op, input logic [4:0] amt, input logic [31:0] d,
                      input logic [4:0] tag, input logic [31:0] exp);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_op = op; in_amount = amt; in_data = d; in_tag = tag;
    for (int w = 0; w < 50 && !ok; w++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else send_waits++;
    end
    if (ok) expect_result(exp, tag, op);
    else begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int w = 0; w < 100 && sb.size() != 0; w++) @(negedge clk);
    chk(name, sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1);
  end

  initial begin
    vec_t tbl [11];
    int lat1, lat2, lat5, idx0, w0, accepts, stable_bad, pops0;
    logic [31:0] d2, d5, hold_d;
    logic [4:0] hold_t;
    logic hold_v;

    tbl[0]  = '{2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000};
    tbl[1]  = '{2'b10, 5'd4,  32'h8000_00F0, 32'hF800_000F};
    tbl[2]  = '{2'b01, 5'd4,  32'h8000_00F0, 32'h0800_000F};
    tbl[3]  = '{2'b00, 5'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[4]  = '{2'b11, 5'd8,  32'h1234_5678, ROT ? 32'h7812_3456 : 32'h1234_5678};
    tbl[5]  = '{2'b10, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000};
    tbl[6]  = '{2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001};
    tbl[7]  = '{2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF};
    tbl[8]  = '{2'b00, 5'd4,  32'h1234_5678, 32'h2345_6780};
    tbl[9]  = '{2'b10, 5'd30, 32'h4000_0000, 32'h0000_0001};
    tbl[10] = '{2'b11, 5'd1,  32'h0000_0001, ROT ? 32'h8000_0000 : 32'h0000_0001};

    reset = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_amount = 5'd0;
    in_data = 32'd0; in_tag = 5'd0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
    chk("rst_out_zero", {31'd0, out_zero}, 32'd1);
    chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Latency for LPS=1, 2 and 5 from one transfer
    lat1 = 0; lat2 = 0; lat5 = 0; d2 = 32'd0; d5 = 32'd0;
    send(2'b00, 5'd31, 32'h0000_0001, 5'd7, 32'h8000_0000);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (out_valid && lat1 == 0) lat1 = n;
      if (a2_out_valid && lat2 == 0) begin lat2 = n; d2 = a2_out_data; end
      if (a5_out_valid && lat5 == 0) begin lat5 = n; d5 = a5_out_data; end
      @(posedge clk);
    end
    #1;
    chk("latency_lps1", lat1, 32'd5);
    chk("latency_lps2", lat2, 32'd3);
    chk("latency_lps5", lat5, 32'd1);
    chk("data_lps2", d2, 32'h8000_0000);
    chk("data_lps5", d5, 32'h8000_0000);
    drain("drain_latency");

    // Directed vectors, back to back
    for (int i = 0; i < 11; i++) send(tbl[i].op, tbl[i].amt, tbl[i].data, 5'(i), tbl[i].exp);
    drain("drain_table");

    // Stream of 20 random ops, tags 0..19
    idx0 = pop_cyc.size();
    w0 = send_waits;
    for (int t = 0; t < 20; t++) begin
      logic [1:0] op; logic [4:0] a; logic [31:0] d;
      op = 2'($urandom_range(0, 3)); a = 5'($urandom_range(0, 31)); d = $urandom;
      send(op, a, d, 5'(t), model(op, a, d));
    end
    drain("drain_stream");
    chk("stream_in_ready_waits", send_waits - w0, 32'd0);
    chk("stream_count", pop_cyc.size() - idx0, 32'd20);
    chk("stream_spacing", (pop_cyc.size() == idx0 + 20) ? pop_cyc[idx0 + 19] - pop_cyc[idx0] : -1, 32'd19);

    // Backpressure on an empty pipe: exactly LAT ops accepted
    out_ready = 1'b0;
    accepts = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_op = 2'b00; in_amount = 5'(c); in_data = 32'h1; in_tag = 5'(20 + c);
      @(negedge clk);
      if (in_ready) begin
        accepts++;
        expect_result(32'h1 << c, 5'(20 + c), 2'b00);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("fill_accepts", accepts, 32'd5);
    chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    drain("drain_fill");

    // Stall for 10 cycles in the middle of a stream
    idx0 = pop_cyc.size();
    stable_bad = 0;
    hold_v = 1'b0;
    fork
      begin
        for (int t = 0; t < 16; t++) begin
          logic [1:0] op; logic [4:0] a; logic [31:0] d;
          op = 2'($urandom_range(0, 3)); a = 5'($urandom_range(0, 31)); d = $urandom;
          send(op, a, d, 5'(t), model(op, a, d));
        end
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        hold_d = out_data; hold_t = out_tag; hold_v = out_valid;
        repeat (10) begin
          @(negedge clk);
          if (out_data !== hold_d || out_tag !== hold_t || out_valid !== hold_v) stable_bad++;
        end
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    chk("stall_valid", {31'd0, hold_v}, 32'd1);
    chk("stall_stable", stable_bad, 32'd0);
    drain("drain_stall");
    chk("stall_count", pop_cyc.size() - idx0, 32'd16);

    // Reset with ops in flight and one result on the output
    for (int t = 0; t < 6; t++) send(2'b01, 5'(t), 32'hFFFF_0000, 5'(t), 32'hFFFF_0000 >> t);
    #1;
    chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    chk("midrst_out_zero", {31'd0, out_zero}, 32'd1);
    sb.delete();
    pops0 = pop_cyc.size();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_stale", pop_cyc.size() - pops0, 32'd0);
    chk("midrst_idle_valid", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
